// File: rtl/panel_entry_ctrl_pkg.sv
// Shared definitions for the front-panel entry sequencer: FSM states,
// register-select codes, key-vector bit layout and key priority helpers.
package panel_entry_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_REQ = 2'd1,
    ST_INC    = 2'd2,
    ST_RD_REQ = 2'd3
  } state_e;

  localparam logic [2:0] REG_A  = 3'd0;
  localparam logic [2:0] REG_X  = 3'd1;
  localparam logic [2:0] REG_Y  = 3'd2;
  localparam logic [2:0] REG_SP = 3'd3;
  localparam logic [2:0] REG_PC = 3'd4;

  // Packed key vector: {toreg[4:0], dec, stinc, load, hex[15:0]}
  localparam int KEY_W    = 24;
  localparam int KB_HEX   = 0;
  localparam int KB_LOAD  = 16;
  localparam int KB_STINC = 17;
  localparam int KB_DEC   = 18;
  localparam int KB_TOREG = 19;

  function automatic logic [3:0] lowest_hex(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] lowest_reg(input logic [4:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/panel_entry_ctrl_key_edge.sv
// Rising-edge detector for debounced key levels. The previous-level register
// resets to all-ones so a key held through reset must be released first.
module key_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_level,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) r_prev <= '1;
    else        r_prev <= i_level;
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/panel_entry_ctrl.sv
// Front-panel monitor sequencer: turns key events into address/data entry,
// memory read/write handshakes and CPU register writes.
module panel_entry_ctrl
  import panel_entry_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       key_hex,
  input  logic              key_load,
  input  logic              key_stinc,
  input  logic              key_dec,
  input  logic [4:0]        key_toreg,
  input  logic              halted,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              reg_wr,
  output logic [2:0]        reg_sel,
  output logic [ADDR_W-1:0] reg_wdata,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [7:0]        disp_data,
  output logic              mode_data,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [KEY_W-1:0]  w_rise;
  logic [ADDR_W-1:0] w_addr_dec;
  logic [3:0]        w_hex_idx;
  logic [2:0]        w_reg_idx;
  logic              w_timeout;

  state_e            r_state;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_reg_wr;
  logic [2:0]        r_reg_sel;
  logic [ADDR_W-1:0] r_reg_wdata;
  logic [ADDR_W-1:0] r_disp_addr;
  logic [7:0]        r_disp_data;
  logic              r_mode_data;
  logic              r_err;

  key_edge #(.W(KEY_W)) u_key_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level ({key_toreg, key_dec, key_stinc, key_load, key_hex}),
    .o_rise  (w_rise)
  );

  assign w_addr_dec = r_disp_addr - ADDR_W'(1);
  assign w_hex_idx  = lowest_hex(w_rise[KB_HEX +: 16]);
  assign w_reg_idx  = lowest_reg(w_rise[KB_TOREG +: 5]);
  // Last unacknowledged cycle of the wait budget: abandon the transaction.
  assign w_timeout  = !mem_ack && (r_wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_reg_wr    <= 1'b0;
      r_reg_sel   <= '0;
      r_reg_wdata <= '0;
      r_disp_addr <= '0;
      r_disp_data <= '0;
      r_mode_data <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_reg_wr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_wait_cnt <= '0;
          if (w_rise[KB_STINC]) begin
            r_err       <= 1'b0;
            r_mode_data <= 1'b1;
            r_req       <= 1'b1;
            r_we        <= 1'b1;
            r_addr      <= r_disp_addr;
            r_wdata     <= r_disp_data;
            r_state     <= ST_WR_REQ;
          end else if (w_rise[KB_DEC]) begin
            r_err       <= 1'b0;
            r_mode_data <= 1'b1;
            r_disp_addr <= w_addr_dec;
            r_req       <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= w_addr_dec;
            r_state     <= ST_RD_REQ;
          end else if (w_rise[KB_LOAD]) begin
            r_err <= 1'b0;
            if (!r_mode_data) begin
              r_mode_data <= 1'b1;
              r_req       <= 1'b1;
              r_we        <= 1'b0;
              r_addr      <= r_disp_addr;
              r_state     <= ST_RD_REQ;
            end else begin
              r_mode_data <= 1'b0;
            end
          end else if (|w_rise[KB_TOREG +: 5]) begin
            if (halted) begin
              r_err     <= 1'b0;
              r_reg_wr  <= 1'b1;
              r_reg_sel <= w_reg_idx;
              // SP/PC take the full entry value; A/X/Y take the data byte
              if (w_reg_idx == REG_SP || w_reg_idx == REG_PC)
                r_reg_wdata <= r_disp_addr;
              else
                r_reg_wdata <= {{(ADDR_W-8){1'b0}}, r_disp_data};
            end else begin
              r_err <= 1'b1;
            end
          end else if (|w_rise[KB_HEX +: 16]) begin
            r_err <= 1'b0;
            if (r_mode_data) r_disp_data <= {r_disp_data[3:0], w_hex_idx};
            else             r_disp_addr <= {r_disp_addr[ADDR_W-5:0], w_hex_idx};
          end
        end
        ST_WR_REQ: begin
          if (mem_ack) begin
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_disp_addr <= r_disp_addr + ADDR_W'(1);
            r_state     <= ST_INC;
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        ST_INC: begin
          r_wait_cnt <= '0;
          r_req      <= 1'b1;
          r_we       <= 1'b0;
          r_addr     <= r_disp_addr;
          r_state    <= ST_RD_REQ;
        end
        ST_RD_REQ: begin
          if (mem_ack) begin
            r_req       <= 1'b0;
            r_disp_data <= mem_rdata;
            r_state     <= ST_IDLE;
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign reg_wr    = r_reg_wr;
  assign reg_sel   = r_reg_sel;
  assign reg_wdata = r_reg_wdata;
  assign disp_addr = r_disp_addr;
  assign disp_data = r_disp_data;
  assign mode_data = r_mode_data;
  assign busy      = (r_state != ST_IDLE);
  assign err       = r_err;

endmodule

// File: tb/tb_panel_entry_ctrl.sv
// Directed bench for panel_entry_ctrl: key entry, memory handshakes with wrap,
// register writes, timeout, reset behaviour and key priority.
module tb_panel_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] key_hex;
  logic        key_load, key_stinc, key_dec;
  logic [4:0]  key_toreg;
  logic        halted;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        reg_wr;
  logic [2:0]  reg_sel;
  logic [15:0] reg_wdata, disp_addr;
  logic [7:0]  disp_data;
  logic        mode_data, busy, err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_regwr = 0;

  localparam logic [23:0] K_LOAD  = 24'h01_0000;
  localparam logic [23:0] K_STINC = 24'h02_0000;
  localparam logic [23:0] K_DEC   = 24'h04_0000;
  localparam logic [23:0] K_TO_A  = 24'h08_0000;
  localparam logic [23:0] K_TO_PC = 24'h80_0000;

  panel_entry_ctrl #(.ADDR_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .key_hex(key_hex), .key_load(key_load),
    .key_stinc(key_stinc), .key_dec(key_dec), .key_toreg(key_toreg),
    .halted(halted), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .reg_wr(reg_wr), .reg_sel(reg_sel), .reg_wdata(reg_wdata),
    .disp_addr(disp_addr), .disp_data(disp_data), .mode_data(mode_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reg_wr) n_regwr++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_keys(input logic [23:0] v);
    key_hex   = v[15:0];
    key_load  = v[16];
    key_stinc = v[17];
    key_dec   = v[18];
    key_toreg = v[23:19];
  endtask

  task automatic press(input logic [23:0] v);
    drive_keys(v);
    tick();
    drive_keys(24'h0);
    tick();
  endtask

  task automatic press_hex(input int d);
    logic [23:0] v;
    v = 24'h1 << d;
    press(v);
  endtask

  task automatic serve(input string tag, input logic we, input logic [15:0] addr,
                       input logic [7:0] wd, input logic [7:0] rd);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, mem_req, 1);
    if (mem_req) begin
      check({tag, "_we"}, mem_we, we);
      check({tag, "_addr"}, mem_addr, addr);
      if (we) check({tag, "_wdata"}, mem_wdata, wd);
      mem_rdata = rd;
      mem_ack   = 1'b1;
      tick();
      mem_ack   = 1'b0;
      check({tag, "_reqlow"}, mem_req, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; halted = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    drive_keys(24'h0);
    repeat (3) tick();
    check("rst_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", disp_addr, 16'h0000);
    check("rst_data", disp_data, 8'h00);
    check("rst_mode", mode_data, 0);
    check("rst_err", err, 0);
    check("rst_regwr", reg_wr, 0);
    rst_n = 1'b1;
    tick();

    // Address entry and load
    press_hex(1); press_hex(2); press_hex(3); press_hex(4);
    check("entry_addr", disp_addr, 16'h1234);
    press(K_LOAD);
    serve("load_rd", 1'b0, 16'h1234, 8'h00, 8'hA9);
    check("load_data", disp_data, 8'hA9);
    check("load_mode", mode_data, 1);
    check("load_busy", busy, 0);

    // Data entry and store+increment
    press_hex(14); press_hex(10);
    check("entry_data", disp_data, 8'hEA);
    press(K_STINC);
    serve("stinc_wr", 1'b1, 16'h1234, 8'hEA, 8'h00);
    serve("stinc_rd", 1'b0, 16'h1235, 8'h00, 8'h5C);
    check("stinc_addr", disp_addr, 16'h1235);
    check("stinc_data", disp_data, 8'h5C);

    // Wrap on increment and decrement
    press(K_LOAD);
    check("load_dmode", mode_data, 0);
    check("load_dbusy", busy, 0);
    repeat (4) press_hex(15);
    check("entry_ffff", disp_addr, 16'hFFFF);
    press(K_STINC);
    serve("wrap_wr", 1'b1, 16'hFFFF, 8'h5C, 8'h00);
    serve("wrap_rd", 1'b0, 16'h0000, 8'h00, 8'h11);
    check("wrap_addr", disp_addr, 16'h0000);
    check("wrap_mode", mode_data, 1);
    press(K_DEC);
    serve("dec_rd", 1'b0, 16'hFFFF, 8'h00, 8'h22);
    check("dec_addr", disp_addr, 16'hFFFF);
    check("dec_data", disp_data, 8'h22);

    // Register write refused while running, accepted while halted
    press(K_TO_A);
    check("toreg_run_err", err, 1);
    check("toreg_run_nowr", n_regwr, 0);
    press(K_LOAD);
    check("err_cleared", err, 0);
    press_hex(0); press_hex(2); press_hex(0); press_hex(0);
    check("entry_0200", disp_addr, 16'h0200);
    halted = 1'b1;
    drive_keys(K_TO_PC);
    tick();
    check("topc_wr", reg_wr, 1);
    check("topc_sel", reg_sel, 3'd4);
    check("topc_wdata", reg_wdata, 16'h0200);
    drive_keys(24'h0);
    tick();
    check("topc_wr_end", reg_wr, 0);
    check("topc_pulses", n_regwr, 1);
    halted = 1'b0;

    // Timeout with keys pressed while busy
    drive_keys(K_LOAD);
    tick();
    drive_keys(24'h0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req) n++;
      else if (n > 0) break;
      if (i == 2) drive_keys(24'h0020);
      if (i == 3) drive_keys(24'h0);
      if (i == 4) drive_keys(K_STINC);
      if (i == 5) drive_keys(24'h0);
      tick();
    end
    check("to_req_cycles", n, 8);
    check("to_err", err, 1);
    check("to_busy", busy, 0);
    check("to_addr", disp_addr, 16'h0200);
    check("to_data", disp_data, 8'h22);

    // Reset mid-transaction with a key held through reset
    drive_keys(K_STINC);
    tick();
    check("midrst_req_on", mem_req, 1);
    rst_n = 1'b0;
    tick();
    check("midrst_req_off", mem_req, 0);
    check("midrst_addr", disp_addr, 16'h0000);
    check("midrst_err", err, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("held_busy", busy, 0);
    check("held_req", mem_req, 0);
    drive_keys(24'h0);
    tick();
    check("midrst_regwr", n_regwr, 1);

    // Simultaneous stinc and hex: stinc wins
    drive_keys(K_STINC | 24'h0080);
    tick();
    drive_keys(24'h0);
    check("prio_addr", disp_addr, 16'h0000);
    serve("prio_wr", 1'b1, 16'h0000, 8'h00, 8'h00);
    serve("prio_rd", 1'b0, 16'h0001, 8'h00, 8'h33);
    check("prio_addr2", disp_addr, 16'h0001);
    check("prio_data", disp_data, 8'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
